// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction at a time.
// Formats store data, extracts and extends load data, and flags bad accesses.
module lsu #(
   parameter int DataWidth = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DataWidth-1:0] alu_result,
   input  logic [DataWidth-1:0] store_data,
   input  logic [2:0]           funct3,
   input  logic                 is_store,
   output logic                 resp_valid,
   output logic [DataWidth-1:0] load_data,
   output logic                 err,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [DataWidth-1:0] mem_addr,
   output logic [DataWidth-1:0] mem_wdata,
   output logic [3:0]           mem_wstrb,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [DataWidth-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [2:0]           f3_q;
   logic [1:0]           off_q;
   logic                 accept;
   logic                 bad_f3;
   logic                 misal;
   logic                 bad;
   logic [DataWidth-1:0] wdata_fmt;
   logic [3:0]           wstrb_fmt;
   logic [15:0]          shifted;
   logic [DataWidth-1:0] ext;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // Stores only allow B/H/W; loads additionally allow BU/HU.
   always_comb begin
      bad_f3 = 1'b0;
      misal  = 1'b0;
      if (is_store) begin
         bad_f3 = funct3[2] || (funct3[1:0] == 2'b11);
      end else begin
         bad_f3 = (funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11);
      end
      unique case (funct3[1:0])
         2'b01:   misal = alu_result[0];
         2'b10:   misal = |alu_result[1:0];
         default: misal = 1'b0;
      endcase
      bad = bad_f3 || misal;
   end

   always_comb begin
      wdata_fmt = store_data;
      wstrb_fmt = 4'b1111;
      unique case (funct3[1:0])
         2'b00: begin
            wdata_fmt = {4{store_data[7:0]}};
            wstrb_fmt = 4'b0001 << alu_result[1:0];
         end
         2'b01: begin
            wdata_fmt = {2{store_data[15:0]}};
            wstrb_fmt = 4'b0011 << alu_result[1:0];
         end
         default: begin
            wdata_fmt = store_data;
            wstrb_fmt = 4'b1111;
         end
      endcase
      if (!is_store) begin
         wstrb_fmt = 4'b0000;
      end
   end

   always_comb begin
      shifted = 16'(mem_rdata >> {off_q, 3'b000});
      unique case (f3_q)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ext = {24'h0, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ext = {16'h0, shifted[15:0]};
         default: ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = bad ? RESP : REQ;
         REQ:  if (mem_gnt) state_nx = mem_we ? RESP : WAIT;
         WAIT: if (mem_rvalid) state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req    <= 1'b0;
         resp_valid <= 1'b0;
         err        <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= 4'b0000;
         load_data  <= '0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
      end else begin
         mem_req    <= (state_nx == REQ);
         resp_valid <= (state_nx == RESP);
         if (accept) begin
            f3_q      <= funct3;
            off_q     <= alu_result[1:0];
            err       <= bad;
            mem_we    <= is_store;
            mem_addr  <= {alu_result[DataWidth-1:2], 2'b00};
            mem_wdata <= wdata_fmt;
            mem_wstrb <= wstrb_fmt;
         end else if (state == RESP) begin
            err <= 1'b0;
         end
         if (state == WAIT && mem_rvalid) begin
            load_data <= ext;
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: byte-level reference memory, scoreboard queues,
// randomized memory latency and a mid-transaction reset.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] alu_result = '0;
   logic [31:0] store_data = '0;
   logic [2:0]  funct3 = '0;
   logic        is_store = 1'b0;
   logic        resp_valid;
   logic [31:0] load_data;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   lsu #(.DataWidth(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .alu_result(alu_result), .store_data(store_data),
      .funct3(funct3), .is_store(is_store),
      .resp_valid(resp_valid), .load_data(load_data), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        err;
      logic [31:0] ld;
      int          lat;
      int          acc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mreq_t;

   resp_t       sq[$];
   mreq_t       mq[$];
   logic [31:0] mem_arr[bit [31:0]];
   logic [7:0]  ref_b[bit [31:0]];
   logic [31:0] last_ld = '0;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          glo = 0, ghi = 0, rlo = 0, rhi = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(logic [31:0] wa);
      return (wa * 32'h9E3779B1) ^ 32'h5A5A0FF0;
   endfunction

   function automatic logic [31:0] word_rd(logic [31:0] wa);
      if (mem_arr.exists(wa)) return mem_arr[wa];
      return init_word(wa);
   endfunction

   function automatic logic [7:0] rbyte(logic [31:0] a);
      logic [31:0] w;
      if (ref_b.exists(a)) return ref_b[a];
      w = init_word(a & ~32'h3);
      return w[8*a[1:0] +: 8];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      mem_arr[a] = w;
      for (int k = 0; k < 4; k++) ref_b[a + k] = w[8*k +: 8];
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                        input logic [2:0] f3, input logic st,
                        input bit track);
      int    n, k, lat;
      bit    fixed;
      logic  illegal, e;
      logic [31:0] v;
      mreq_t m;
      resp_t r;
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: req_ready stuck at %b", req_ready);
         return;
      end
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      e = illegal || ((a % n) != 0);
      fixed = (glo == ghi) && (rlo == rhi);
      r.ld = last_ld;
      if (e) begin
         lat = 1;
      end else if (st) begin
         m.addr = a & ~32'h3;
         m.we = 1'b1;
         m.wstrb = 4'((1 << n) - 1) << a[1:0];
         for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = sd[8*(i % n) +: 8];
         for (int i = 0; i < n; i++) ref_b[a + i] = sd[8*i +: 8];
         mq.push_back(m);
         lat = fixed ? 2 + glo : -1;
      end else begin
         m.addr = a & ~32'h3;
         m.we = 1'b0;
         m.wstrb = 4'b0000;
         m.wdata = '0;
         mq.push_back(m);
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = rbyte(a + i);
         if (!f3[2] && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
         end
         last_ld = v;
         r.ld = v;
         lat = fixed ? 3 + glo + rlo : -1;
      end
      r.err = e;
      r.lat = lat;
      r.acc = cyc;
      sq.push_back(r);
      req_valid = 1'b1;
      alu_result = a;
      store_data = sd;
      funct3 = f3;
      is_store = st;
      @(negedge clk);
      req_valid = 1'b0;
      alu_result = $urandom;
      store_data = $urandom;
      funct3 = 3'($urandom_range(0, 7));
      is_store = 1'($urandom_range(0, 1));
      if (track && lat >= 0) begin
         k = 1;
         while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
         end
         chk("ready_gap", k, lat + 1);
      end
   endtask

   // Response monitor.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid) begin
            if (sq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: err=%b load_data=%h", err, load_data);
            end else begin
               r = sq.pop_front();
               chk("err", err, r.err);
               chk("load_data", load_data, r.ld);
               if (r.lat >= 0) chk("latency", cyc - r.acc, r.lat);
            end
         end
      end
   end

   // Memory responder and request-side checker.
   initial begin
      int          gcnt, gdly, rcnt, rdly;
      bit          in_req, rd_pend;
      logic [31:0] snap_a, snap_d, rd_addr, w;
      mreq_t       m;
      gcnt = 0; gdly = 0; rcnt = 0; rdly = 0;
      in_req = 0; rd_pend = 0;
      snap_a = '0; snap_d = '0; rd_addr = '0;
      forever begin
         @(negedge clk);
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (rd_pend) begin
            if (rcnt >= rdly) begin
               mem_rvalid = 1'b1;
               mem_rdata = word_rd(rd_addr);
               rd_pend = 0;
            end else begin
               rcnt++;
            end
         end else begin
            if ($urandom_range(0, 3) == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = $urandom;
            end
            if (mem_req) begin
               if (!in_req) begin
                  in_req = 1;
                  gcnt = 0;
                  gdly = $urandom_range(ghi, glo);
                  snap_a = mem_addr;
                  snap_d = mem_wdata;
               end else begin
                  chk("req_stable_addr", mem_addr, snap_a);
                  chk("req_stable_wdata", mem_wdata, snap_d);
               end
               if (gcnt >= gdly) begin
                  mem_gnt = 1'b1;
                  in_req = 0;
                  if (mq.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_mem_req: addr=%h we=%b", mem_addr, mem_we);
                  end else begin
                     m = mq.pop_front();
                     chk("mem_addr", mem_addr, m.addr);
                     chk("mem_we", mem_we, m.we);
                     chk("mem_wstrb", mem_wstrb, m.wstrb);
                     if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                  end
                  if (mem_we) begin
                     w = word_rd(mem_addr);
                     for (int i = 0; i < 4; i++) begin
                        if (mem_wstrb[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                     end
                     mem_arr[mem_addr] = w;
                  end else begin
                     rd_pend = 1;
                     rd_addr = mem_addr;
                     rcnt = 0;
                     rdly = $urandom_range(rhi, rlo);
                  end
               end else begin
                  gcnt++;
               end
            end else begin
               in_req = 0;
            end
         end
      end
   end

   task automatic chk_reset_vals();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals();

      issue(32'h100, 32'hDEADBEEF, 3'b010, 1'b1, 1);
      issue(32'h103, 32'h000000A5, 3'b000, 1'b1, 1);
      issue(32'h102, 32'h00001234, 3'b001, 1'b1, 1);

      preload(32'h200, 32'h80F07F81);
      issue(32'h200, 32'h0, 3'b000, 1'b0, 1);
      issue(32'h200, 32'h0, 3'b100, 1'b0, 1);
      issue(32'h202, 32'h0, 3'b001, 1'b0, 1);
      issue(32'h202, 32'h0, 3'b101, 1'b0, 1);
      issue(32'h201, 32'h0, 3'b000, 1'b0, 1);

      issue(32'h101, 32'h0, 3'b010, 1'b0, 1);
      issue(32'h203, 32'h5555, 3'b001, 1'b1, 1);
      issue(32'h200, 32'h0, 3'b011, 1'b0, 1);

      glo = 3; ghi = 3; rlo = 2; rhi = 2;
      issue(32'h200, 32'h0, 3'b010, 1'b0, 1);

      glo = 0; ghi = 3; rlo = 0; rhi = 3;
      repeat (300) begin
         issue(32'h1000 + $urandom_range(0, 31), $urandom,
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
      end

      k = 0;
      while (sq.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_resp", sq.size(), 0);

      glo = 0; ghi = 0; rlo = 6; rhi = 6;
      issue(32'h200, 32'h0, 3'b010, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_ready", req_ready, 1);
      chk("async_mem_req", mem_req, 0);
      chk("async_resp_valid", resp_valid, 0);
      sq.delete();
      last_ld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk_reset_vals();
      chk("drain_mem", mq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
